bus_apb_bridge: RTL and testbench

- Bridges the simple on-chip master bus to an APB fabric with `NUM_SLAVES` completers.
- Fields used from the simple bus:
  - request: `bus_ena`, `bus_wstb`, `bus_addr`, `bus_wdata`
  - response: `bus_wait`, `bus_rdata`, `bus_slverr`
- Per transfer the bridge:
  - decodes the address to one `psel` line;
  - runs the APB SETUP/ACCESS sequence and bounds the wait with a programmable timeout;
  - returns data and error to the master.
- Sits between any bus master agent/DUT port and the APB peripheral cluster.

---
 rtl/bus_apb_pkg.sv | 27 ++
 rtl/bus_apb_timeout.sv | 44 ++++
 rtl/bus_apb_bridge.sv | 127 ++++++++++++
 tb/tb_bus_apb_bridge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_apb_pkg
// Brief    : Shared types and helpers for the simple-bus to APB bridge.
// Revision : 1.0
// ============================================================================
package bus_apb_pkg;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETUP  = 2'd1;
  localparam logic [1:0] c_ST_ACCESS = 2'd2;
  localparam logic [1:0] c_ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = c_ST_IDLE,
    SETUP  = c_ST_SETUP,
    ACCESS = c_ST_ACCESS,
    RESP   = c_ST_RESP
  } apb_state_e;

  // Completer index width; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_apb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : bus_apb_timeout
// Brief    : Saturating ACCESS-phase counter; expired flags the last allowed cycle.
// Revision : 1.0
// ============================================================================
module bus_apb_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_cnt
      localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en && (r_cnt != c_MAX)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // The count lags the cycle number by one, so LAST marks the N-th cycle.
      assign expired = en && (r_cnt >= c_LAST);
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bus_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : bus_apb_bridge
// Brief    : Simple on-chip master bus to multi-completer APB bridge.
// Revision : 1.0
// ============================================================================
module bus_apb_bridge
  import bus_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             bus_ena,
  input  logic [DATA_WIDTH/8-1:0]          bus_wstb,
  input  logic [ADDR_WIDTH-1:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0]            bus_wdata,
  output logic                             bus_wait,
  output logic [DATA_WIDTH-1:0]            bus_rdata,
  output logic                             bus_slverr,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = sel_width(NUM_SLAVES);

  apb_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [STRB_W-1:0]     r_wstb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_slverr;
  logic [SEL_W-1:0]      r_idx;

  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic                  w_dec_err;
  logic                  w_in_xfer;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic                  w_expired;

  // Any address bit above the completer window counts toward the index.
  assign w_idx_full  = bus_addr >> SLV_ADDR_WIDTH;
  assign w_dec_err   = (w_idx_full >= ADDR_WIDTH'(NUM_SLAVES));

  assign w_in_xfer   = (r_state == SETUP) || (r_state == ACCESS);
  assign w_sel_ready = pready[r_idx];
  assign w_sel_err   = pslverr[r_idx];
  assign w_sel_rdata = prdata[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

  assign psel       = w_in_xfer ? (NUM_SLAVES'(1) << r_idx) : '0;
  assign penable    = (r_state == ACCESS);
  assign pwrite     = |r_wstb;
  assign paddr      = r_addr;
  assign pwdata     = r_wdata;
  assign pstrb      = r_wstb;

  assign bus_wait   = bus_ena & (r_state != RESP);
  assign bus_rdata  = r_rdata;
  assign bus_slverr = r_slverr;

  bus_apb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (r_state == SETUP),
    .en      (r_state == ACCESS),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wstb   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus_ena) begin
            r_addr   <= bus_addr;
            r_wstb   <= bus_wstb;
            r_wdata  <= bus_wdata;
            r_idx    <= w_idx_full[SEL_W-1:0];
            r_rdata  <= '0;
            r_slverr <= w_dec_err;
            r_state  <= w_dec_err ? RESP : SETUP;
          end
        end
        SETUP: r_state <= ACCESS;
        ACCESS: begin
          // A ready completer wins over a timeout landing in the same cycle.
          if (w_sel_ready) begin
            r_rdata  <= pwrite ? '0 : w_sel_rdata;
            r_slverr <= w_sel_err;
            r_state  <= RESP;
          end else if (w_expired) begin
            r_rdata  <= '0;
            r_slverr <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_apb_bridge
// Brief    : Scoreboard bench for bus_apb_bridge with a simple APB completer model.
// Revision : 1.0
// ============================================================================
module tb_bus_apb_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SW  = 12;
  localparam int TO  = 8;
  localparam int STW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bus_ena;
  logic [STW-1:0]   bus_wstb;
  logic [AW-1:0]    bus_addr;
  logic [DW-1:0]    bus_wdata;
  logic             bus_wait;
  logic [DW-1:0]    bus_rdata;
  logic             bus_slverr;
  logic [NS-1:0]    psel;
  logic             penable;
  logic             pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [STW-1:0]   pstrb;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]    pready;
  logic [NS-1:0]    pslverr;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bus_apb_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .SLV_ADDR_WIDTH (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_ena    (bus_ena),
    .bus_wstb   (bus_wstb),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wait   (bus_wait),
    .bus_rdata  (bus_rdata),
    .bus_slverr (bus_slverr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // Completer model: the selected slave answers after cfg_wait ACCESS wait
  // cycles; unselected slaves assert ready/error to expose bad muxing.
  int          cfg_wait = 0;
  logic        cfg_err  = 1'b0;
  logic [DW-1:0] slv_data [NS];
  int          acc_cnt  = 0;

  always @(posedge clk) acc_cnt <= (penable && !(|(psel & pready))) ? acc_cnt + 1 : 0;

  always_comb begin
    pready  = '1;
    pslverr = '1;
    prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      pready[i]            = psel[i] ? (penable && (acc_cnt == cfg_wait)) : 1'b1;
      pslverr[i]           = psel[i] ? cfg_err : 1'b1;
      prdata[i*DW +: DW]   = psel[i] ? slv_data[i] : {28'hBAD0000, 4'(i)};
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [NS-1:0]  exp_psel   = '0;
  logic [AW-1:0]  exp_paddr  = '0;
  logic           exp_pwrite = 1'b0;
  logic [DW-1:0]  exp_pwdata = '0;
  logic [STW-1:0] exp_pstrb  = '0;
  int             psel_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops one expectation per completion cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus_ena && !bus_wait) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_completion: got completion, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("bus_rdata",  bus_rdata,  e.rdata);
        chk("bus_slverr", bus_slverr, e.slverr);
        chk("done_cycle", cyc,        e.cyc);
      end
    end
  end

  // APB monitor: checks select and stability of every SETUP/ACCESS cycle.
  initial forever begin
    @(negedge clk);
    if (psel != '0) begin
      chk("psel",    psel,    exp_psel);
      chk("penable", penable, (psel_cycles > 0));
      chk("pwrite",  pwrite,  exp_pwrite);
      chk("paddr",   paddr,   exp_paddr);
      chk("pwdata",  pwdata,  exp_pwdata);
      chk("pstrb",   pstrb,   exp_pstrb);
      psel_cycles++;
    end
  end

  task automatic drive(input logic [AW-1:0] a, input logic [STW-1:0] s, input logic [DW-1:0] d,
                       input logic [NS-1:0] epsel);
    bus_ena    = 1'b1;
    bus_addr   = a;
    bus_wstb   = s;
    bus_wdata  = d;
    exp_psel   = epsel;
    exp_paddr  = a;
    exp_pwrite = |s;
    exp_pwdata = d;
    exp_pstrb  = s;
    psel_cycles = 0;
  endtask

  task automatic start_req(input logic [AW-1:0] a, input logic [STW-1:0] s, input logic [DW-1:0] d,
                           input logic [NS-1:0] epsel, input logic [DW-1:0] erd,
                           input logic eerr, input int lat);
    exp_t e;
    drive(a, s, d, epsel);
    e.rdata  = erd;
    e.slverr = eerr;
    e.cyc    = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int epcyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus_ena && !bus_wait) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL completion_wait: got no completion in 40 cycles, expected one");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    chk("psel_cycles", psel_cycles, epcyc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_ena   = 1'b0;
    bus_wstb  = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    for (int i = 0; i < NS; i++) slv_data[i] = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel",    psel,       '0);
    chk("rst_penable", penable,    1'b0);
    chk("rst_pwrite",  pwrite,     1'b0);
    chk("rst_paddr",   paddr,      '0);
    chk("rst_pwdata",  pwdata,     '0);
    chk("rst_pstrb",   pstrb,      '0);
    chk("rst_rdata",   bus_rdata,  '0);
    chk("rst_slverr",  bus_slverr, 1'b0);
    chk("rst_wait_lo", bus_wait,   1'b0);
    bus_ena = 1'b1;
    #1;
    chk("rst_wait_hi", bus_wait,   1'b1);
    bus_ena = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read slave 1, ready on first ACCESS.
    slv_data[1] = 32'hDEADBEEF;
    cfg_wait = 0;
    cfg_err  = 1'b0;
    start_req(32'h0000_1004, 4'b0000, 32'h0, 4'b0010, 32'hDEADBEEF, 1'b0, 3);
    wait_done(2);
    bus_ena = 1'b0;

    // Write slave 3, five wait cycles; write returns zero data.
    slv_data[3] = 32'hFFFF0000;
    cfg_wait = 5;
    start_req(32'h0000_3010, 4'b0101, 32'h12345678, 4'b1000, 32'h0, 1'b0, 8);
    wait_done(7);
    bus_ena = 1'b0;

    // Decode errors: index past the last slave, and nonzero upper bits.
    start_req(32'h0000_4000, 4'b0000, 32'hAAAA5555, 4'b0000, 32'h0, 1'b1, 1);
    wait_done(0);
    bus_ena = 1'b0;
    start_req(32'h8000_1000, 4'b1111, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
    wait_done(0);
    bus_ena = 1'b0;

    // Timeout after 8 ACCESS cycles.
    slv_data[2] = 32'hCAFEF00D;
    cfg_wait = 1000;
    start_req(32'h0000_2000, 4'b0000, 32'h0, 4'b0100, 32'h0, 1'b1, 10);
    wait_done(9);
    bus_ena = 1'b0;

    // Ready in the 8th ACCESS cycle beats the timeout; completer error kept.
    cfg_wait = 7;
    cfg_err  = 1'b1;
    start_req(32'h0000_2FFC, 4'b0000, 32'h0, 4'b0100, 32'hCAFEF00D, 1'b1, 10);
    wait_done(9);
    bus_ena = 1'b0;

    // Reset pulse mid-ACCESS.
    cfg_wait = 1000;
    cfg_err  = 1'b0;
    drive(32'h0000_1FF0, 4'b1111, 32'h0F0F0F0F, 4'b0010);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_penable", penable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel",    psel,       '0);
    chk("mid_rst_penable", penable,    1'b0);
    chk("mid_rst_pwrite",  pwrite,     1'b0);
    chk("mid_rst_paddr",   paddr,      '0);
    chk("mid_rst_pwdata",  pwdata,     '0);
    chk("mid_rst_pstrb",   pstrb,      '0);
    chk("mid_rst_rdata",   bus_rdata,  '0);
    chk("mid_rst_slverr",  bus_slverr, 1'b0);
    chk("mid_rst_wait",    bus_wait,   1'b1);
    bus_ena = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back reads, slave 0 then slave 2, bus_ena held high.
    cfg_wait = 0;
    slv_data[0] = 32'h01234567;
    slv_data[2] = 32'h89ABCDEF;
    start_req(32'h0000_0008, 4'b0000, 32'h0, 4'b0001, 32'h01234567, 1'b0, 3);
    wait_done(2);
    start_req(32'h0000_2000, 4'b0000, 32'h0, 4'b0100, 32'h89ABCDEF, 1'b0, 3);
    wait_done(2);
    bus_ena = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
